// File: rtl/tdm_voice_mixer.sv
// Stereo mixer for the TDM voice pipeline: pans and mutes each channel sample, then
// accumulates a frame and hands the scaled, saturated L/R words to the I2S transmitter.
module tdm_voice_mixer #(
   parameter  int NUM_CHANNELS = 16,
   parameter  int WIDTH_IN     = 18,
   parameter  int WIDTH_OUT    = 24,
   parameter  int PAN_BITS     = 8,
   parameter  int SHIFT        = 8,
   localparam int CH_W         = $clog2(NUM_CHANNELS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             sample_valid,
   output logic                             sample_ready,
   input  logic [CH_W-1:0]                  sample_ch,
   input  logic [WIDTH_IN-1:0]              sample_in,
   input  logic [NUM_CHANNELS*PAN_BITS-1:0] pan_in,
   input  logic [NUM_CHANNELS-1:0]          mute_in,
   output logic                             out_valid,
   input  logic                             frame_ready,
   output logic [WIDTH_OUT-1:0]             out_left,
   output logic [WIDTH_OUT-1:0]             out_right,
   output logic                             sat_left,
   output logic                             sat_right,
   output logic                             seq_err
);

   localparam int PROD_W = WIDTH_IN + PAN_BITS + 1;
   localparam int ACC_W  = PROD_W + CH_W;
   localparam logic signed [ACC_W-1:0] MAX_V =
      {{(ACC_W-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V =
      {{(ACC_W-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};

   typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_HOLD} state_t;

   state_t                    state_q, state_d;
   logic [CH_W-1:0]           count_q, count_d;
   logic                      drain_q, drain_d;
   logic signed [PROD_W-1:0]  prod_l_q, prod_l_d, prod_r_q, prod_r_d;
   logic signed [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [WIDTH_OUT-1:0]      out_left_q, out_left_d, out_right_q, out_right_d;
   logic                      sat_left_q, sat_left_d, sat_right_q, sat_right_d;
   logic                      out_valid_q, out_valid_d;
   logic                      sample_ready_q, sample_ready_d;
   logic                      seq_err_q, seq_err_d;

   logic                      accept;
   logic [PAN_BITS-1:0]       pan_sel;
   logic                      mute_sel;
   logic signed [PROD_W-1:0]  s_ext, g_l_ext, g_r_ext;

   // Floor shift then clip; MSB of the result is the clip flag.
   function automatic logic [WIDTH_OUT:0] scale_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] sh;
      sh = a >>> SHIFT;
      if (sh > MAX_V)      scale_sat = {1'b1, MAX_V[WIDTH_OUT-1:0]};
      else if (sh < MIN_V) scale_sat = {1'b1, MIN_V[WIDTH_OUT-1:0]};
      else                 scale_sat = {1'b0, sh[WIDTH_OUT-1:0]};
   endfunction

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pan_sel  = '0;
      mute_sel = 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (sample_ch == CH_W'(i)) begin
            pan_sel  = pan_in[i*PAN_BITS +: PAN_BITS];
            mute_sel = mute_in[i];
         end
      end
      s_ext   = {{(PROD_W-WIDTH_IN){sample_in[WIDTH_IN-1]}}, sample_in};
      g_r_ext = {{(PROD_W-PAN_BITS){1'b0}}, pan_sel};
      g_l_ext = {{(PROD_W-PAN_BITS){1'b0}}, ~pan_sel};
      accept  = sample_valid && sample_ready_q;

      state_d        = state_q;
      count_d        = count_q;
      drain_d        = drain_q;
      prod_l_d       = '0;
      prod_r_d       = '0;
      acc_l_d        = acc_l_q + ACC_W'(prod_l_q);
      acc_r_d        = acc_r_q + ACC_W'(prod_r_q);
      out_left_d     = out_left_q;
      out_right_d    = out_right_q;
      sat_left_d     = sat_left_q;
      sat_right_d    = sat_right_q;
      out_valid_d    = out_valid_q;
      sample_ready_d = sample_ready_q;
      seq_err_d      = 1'b0;

      unique case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               seq_err_d = (sample_ch != count_q);
               if (!mute_sel) begin
                  prod_l_d = s_ext * g_l_ext;
                  prod_r_d = s_ext * g_r_ext;
               end
               if (count_q == CH_W'(NUM_CHANNELS-1)) begin
                  count_d        = '0;
                  state_d        = ST_DRAIN;
                  sample_ready_d = 1'b0;
               end else begin
                  count_d = count_q + CH_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            // Second drain cycle: the last product is already in the accumulators.
            drain_d = ~drain_q;
            if (drain_q) begin
               {sat_left_d, out_left_d}   = scale_sat(acc_l_q);
               {sat_right_d, out_right_d} = scale_sat(acc_r_q);
               acc_l_d     = '0;
               acc_r_d     = '0;
               out_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (frame_ready && out_valid_q) begin
               out_valid_d    = 1'b0;
               sample_ready_d = 1'b1;
               state_d        = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only, so all flops sample together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_ACCUM;
         count_q        <= '0;
         drain_q        <= 1'b0;
         prod_l_q       <= '0;
         prod_r_q       <= '0;
         acc_l_q        <= '0;
         acc_r_q        <= '0;
         out_left_q     <= '0;
         out_right_q    <= '0;
         sat_left_q     <= 1'b0;
         sat_right_q    <= 1'b0;
         out_valid_q    <= 1'b0;
         sample_ready_q <= 1'b1;
         seq_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         drain_q        <= drain_d;
         prod_l_q       <= prod_l_d;
         prod_r_q       <= prod_r_d;
         acc_l_q        <= acc_l_d;
         acc_r_q        <= acc_r_d;
         out_left_q     <= out_left_d;
         out_right_q    <= out_right_d;
         sat_left_q     <= sat_left_d;
         sat_right_q    <= sat_right_d;
         out_valid_q    <= out_valid_d;
         sample_ready_q <= sample_ready_d;
         seq_err_q      <= seq_err_d;
      end
   end

   assign sample_ready = sample_ready_q;
   assign out_valid    = out_valid_q;
   assign out_left     = out_left_q;
   assign out_right    = out_right_q;
   assign sat_left     = sat_left_q;
   assign sat_right    = sat_right_q;
   assign seq_err      = seq_err_q;

endmodule

// File: tb/tb_tdm_voice_mixer.sv
// Directed bench for tdm_voice_mixer: default instance plus a SHIFT=0 instance sharing stimulus.
module tb_tdm_voice_mixer;

   logic          clk = 1'b0;
   logic          rst;
   logic          sample_valid;
   logic [3:0]    sample_ch;
   logic [17:0]   sample_in;
   logic [127:0]  pan_in;
   logic [15:0]   mute_in;
   logic          frame_ready;

   logic          sample_ready, out_valid, sat_left, sat_right, seq_err;
   logic [23:0]   out_left, out_right;
   logic          b_sample_ready, b_out_valid, b_sat_left, b_sat_right, b_seq_err;
   logic [23:0]   b_out_left, b_out_right;

   int checks = 0;
   int errors = 0;
   int seq_cnt = 0;
   int seq_base;

   tdm_voice_mixer dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .sample_ch(sample_ch), .sample_in(sample_in), .pan_in(pan_in), .mute_in(mute_in),
      .out_valid(out_valid), .frame_ready(frame_ready), .out_left(out_left),
      .out_right(out_right), .sat_left(sat_left), .sat_right(sat_right), .seq_err(seq_err)
   );

   tdm_voice_mixer #(.SHIFT(0)) dut_b (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(b_sample_ready),
      .sample_ch(sample_ch), .sample_in(sample_in), .pan_in(pan_in), .mute_in(mute_in),
      .out_valid(b_out_valid), .frame_ready(frame_ready), .out_left(b_out_left),
      .out_right(b_out_right), .sat_left(b_sat_left), .sat_right(b_sat_right),
      .seq_err(b_seq_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (seq_err) seq_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [3:0] ch, input logic [17:0] s);
      int n;
      @(negedge clk);
      sample_valid = 1'b1;
      sample_ch    = ch;
      sample_in    = s;
      n = 0;
      while (!sample_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n == 100) check("ready_timeout", {31'd0, sample_ready}, 32'd1);
   endtask

   task automatic send_frame(input logic [17:0] s, input bit swap, input int count);
      logic [3:0] ch;
      for (int i = 0; i < count; i++) begin
         ch = 4'(i);
         if (swap && i == 4) ch = 4'd5;
         if (swap && i == 5) ch = 4'd4;
         accept(ch, s);
      end
   endtask

   // Three negedges after the last accept edge: drain, drain, then the frame is out.
   task automatic drain_check(input string tag, input logic [23:0] exp_l,
                              input logic [23:0] exp_r, input logic exp_sl,
                              input logic exp_sr);
      @(negedge clk);
      sample_valid = 1'b0;
      check({tag, "_drain1_rdy"}, {31'd0, sample_ready}, 32'd0);
      check({tag, "_drain1_ov"}, {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check({tag, "_drain2_ov"}, {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_left"}, {8'd0, out_left}, {8'd0, exp_l});
      check({tag, "_right"}, {8'd0, out_right}, {8'd0, exp_r});
      check({tag, "_sat_l"}, {31'd0, sat_left}, {31'd0, exp_sl});
      check({tag, "_sat_r"}, {31'd0, sat_right}, {31'd0, exp_sr});
   endtask

   task automatic ack(input string tag);
      @(negedge clk);
      frame_ready = 1'b1;
      @(negedge clk);
      frame_ready = 1'b0;
      check({tag, "_ack_ov"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ack_rdy"}, {31'd0, sample_ready}, 32'd1);
   endtask

   initial begin
      rst          = 1'b1;
      sample_valid = 1'b0;
      sample_ch    = '0;
      sample_in    = '0;
      pan_in       = {16{8'd128}};
      mute_in      = '0;
      frame_ready  = 1'b0;

      @(negedge clk);
      check("rst_ov", {31'd0, out_valid}, 32'd0);
      check("rst_left", {8'd0, out_left}, 32'd0);
      check("rst_right", {8'd0, out_right}, 32'd0);
      check("rst_seq", {31'd0, seq_err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_rdy", {31'd0, sample_ready}, 32'd1);

      // Test 1: +1.0 on every channel, centre pan
      seq_base = seq_cnt;
      send_frame(18'h10000, 1'b0, 16);
      drain_check("t1", 24'h07F000, 24'h080000, 1'b0, 1'b0);
      check("t1_seq", 32'(seq_cnt - seq_base), 32'd0);
      ack("t1");

      // Test 2: max positive samples, hard right
      pan_in = {16{8'd255}};
      send_frame(18'h1FFFF, 1'b0, 16);
      drain_check("t2", 24'h000000, 24'h1FDFF0, 1'b0, 1'b0);
      check("t2b_right", {8'd0, b_out_right}, 32'h007FFFFF);
      check("t2b_sat_r", {31'd0, b_sat_right}, 32'd1);
      check("t2b_left", {8'd0, b_out_left}, 32'd0);
      check("t2b_sat_l", {31'd0, b_sat_left}, 32'd0);
      ack("t2");
      check("t2b_sat_r_kept", {31'd0, b_sat_right}, 32'd1);
      check("t2_right_kept", {8'd0, out_right}, 32'h001FDFF0);

      // Test 3: only ch3 live at -1.0, hard left
      pan_in          = {16{8'd128}};
      pan_in[31:24]   = 8'd0;
      mute_in         = 16'hFFF7;
      seq_base        = seq_cnt;
      send_frame(18'h30000, 1'b0, 16);
      drain_check("t3", 24'hFF0100, 24'h000000, 1'b0, 1'b0);
      check("t3_seq", 32'(seq_cnt - seq_base), 32'd0);

      // Test 4: stall in HOLD with samples offered
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         sample_valid = 1'b1;
         sample_ch    = 4'd0;
         sample_in    = 18'h10000;
         check("t4_hold_ov", {31'd0, out_valid}, 32'd1);
         check("t4_hold_rdy", {31'd0, sample_ready}, 32'd0);
         check("t4_hold_left", {8'd0, out_left}, 32'h00FF0100);
      end
      @(negedge clk);
      sample_valid = 1'b0;
      check("t4_hold_last", {8'd0, out_left}, 32'h00FF0100);
      ack("t4");
      check("t4_left_kept", {8'd0, out_left}, 32'h00FF0100);
      pan_in   = {16{8'd128}};
      mute_in  = '0;
      seq_base = seq_cnt;
      send_frame(18'h10000, 1'b0, 16);
      drain_check("t4_next", 24'h07F000, 24'h080000, 1'b0, 1'b0);
      check("t4_seq", 32'(seq_cnt - seq_base), 32'd0);
      ack("t4_next");

      // Test 5: channels 4 and 5 swapped
      seq_base = seq_cnt;
      send_frame(18'h10000, 1'b1, 16);
      drain_check("t5", 24'h07F000, 24'h080000, 1'b0, 1'b0);
      check("t5_seq", 32'(seq_cnt - seq_base), 32'd2);
      ack("t5");

      // Test 6: reset after a partial frame
      send_frame(18'h1FFFF, 1'b0, 7);
      @(negedge clk);
      sample_valid = 1'b0;
      rst          = 1'b1;
      @(negedge clk);
      check("t6_rst_ov", {31'd0, out_valid}, 32'd0);
      check("t6_rst_left", {8'd0, out_left}, 32'd0);
      check("t6_rst_right", {8'd0, out_right}, 32'd0);
      check("t6_rst_sat", {30'd0, sat_left, sat_right}, 32'd0);
      check("t6_rst_seq", {31'd0, seq_err}, 32'd0);
      check("t6b_rst_sat", {30'd0, b_sat_left, b_sat_right}, 32'd0);
      @(negedge clk);
      rst      = 1'b0;
      seq_base = seq_cnt;
      send_frame(18'h10000, 1'b0, 16);
      drain_check("t6", 24'h07F000, 24'h080000, 1'b0, 1'b0);
      check("t6_seq", 32'(seq_cnt - seq_base), 32'd0);
      ack("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
